// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator.
// Sends a PAT_W-bit pattern MSB-first on seq, repeated rep+1 times with an
// optional idle gap of `gap` cycles between repetitions. All outputs are
// registered. Reset is asynchronous and active-high.
// Optional feature, enabled by defining SEQ_GEN_LOOP_EN: adds the input
// `loop`. When loop=1 at start, the burst repeats until abort or reset and
// never pulses done.
module seq_gen #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_DEF = 4'b1001,
    parameter int               CNT_W   = 4,
    parameter int               GAP_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
`ifdef SEQ_GEN_LOOP_EN
    input  logic             loop,
`endif
    output logic             seq,
    output logic             seq_vld,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   shreg_q, shreg_d;      // MSB is the bit currently on seq
    logic [PAT_W-1:0]   pat_q, pat_d;          // latched pattern for reloads
    logic [CNT_W-1:0]   rep_q, rep_d;          // repetitions still to send
    logic [GAP_W-1:0]   gap_q, gap_d;          // latched gap length
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;  // gap cycles shown so far
    logic [BIT_W-1:0]   bit_q, bit_d;          // index of the bit on seq
    logic               seq_d, seq_vld_d, busy_d, done_d;
    logic [PAT_W-1:0]   pat_sel;
    logic               reload;

`ifdef SEQ_GEN_LOOP_EN
    logic loop_q, loop_d;
`else
    logic loop_q;
    assign loop_q = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d   = state_q;
        shreg_d   = shreg_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        bit_d     = bit_q;
        seq_d     = 1'b0;
        seq_vld_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pat_sel   = use_def ? PAT_DEF : pattern;
        reload    = 1'b0;
`ifdef SEQ_GEN_LOOP_EN
        loop_d    = loop_q;
`endif

        case (state_q)
            IDLE: begin
                // abort beats start in the same cycle
                if (start && !abort) begin
                    state_d   = SHIFT;
                    pat_d     = pat_sel;
                    shreg_d   = pat_sel;
                    rep_d     = rep;
                    gap_d     = gap;
                    gap_cnt_d = '0;
                    bit_d     = '0;
                    seq_d     = pat_sel[PAT_W-1];
                    seq_vld_d = 1'b1;
                    busy_d    = 1'b1;
`ifdef SEQ_GEN_LOOP_EN
                    loop_d    = loop;
`endif
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_q != LAST_BIT) begin
                    shreg_d   = shreg_q << 1;
                    bit_d     = bit_q + BIT_W'(1);
                    seq_d     = shreg_q[PAT_W-2];
                    seq_vld_d = 1'b1;
                    busy_d    = 1'b1;
                end else if (rep_q != '0 || loop_q) begin
                    if (gap_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_W'(1);
                        busy_d    = 1'b1;
                    end else begin
                        reload = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == gap_q) begin
                    reload = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    busy_d    = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Start the next repetition from the latched pattern.
        if (reload) begin
            state_d   = SHIFT;
            shreg_d   = pat_q;
            bit_d     = '0;
            gap_cnt_d = '0;
            seq_d     = pat_q[PAT_W-1];
            seq_vld_d = 1'b1;
            busy_d    = 1'b1;
            if (!loop_q) rep_d = rep_q - CNT_W'(1);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            pat_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            bit_q     <= '0;
            seq       <= 1'b0;
            seq_vld   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_GEN_LOOP_EN
            loop_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            bit_q     <= bit_d;
            seq       <= seq_d;
            seq_vld   <= seq_vld_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef SEQ_GEN_LOOP_EN
            loop_q    <= loop_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: table-driven bench for seq_gen plus hand-written sequences
// for asynchronous reset mid-gap and, with SEQ_GEN_LOOP_EN, endless looping.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       use_def = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] rep = '0;
    logic [2:0] gap = '0;
    logic       abort = 1'b0;
    logic       loop = 1'b0;
    logic       seq, seq_vld, busy, done;

    int total = 0;
    int bad   = 0;

    seq_gen #(.PAT_W(4), .PAT_DEF(4'b1001), .CNT_W(4), .GAP_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .use_def (use_def),
        .pattern (pattern),
        .rep     (rep),
        .gap     (gap),
        .abort   (abort),
`ifdef SEQ_GEN_LOOP_EN
        .loop    (loop),
`endif
        .seq     (seq),
        .seq_vld (seq_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected after the following edge.
    typedef struct {
        logic       st;
        logic       ud;
        logic [3:0] pat;
        logic [3:0] rp;
        logic [2:0] gp;
        logic       ab;
        logic [3:0] exp;  // {seq, seq_vld, busy, done}
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic st, input logic ud, input logic [3:0] pat,
                              input logic [3:0] rp, input logic [2:0] gp, input logic ab,
                              input logic s, input logic vl, input logic b, input logic d);
        vec_t r;
        r.st = st; r.ud = ud; r.pat = pat; r.rp = rp; r.gp = gp; r.ab = ab;
        r.exp = {s, vl, b, d};
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b ({seq,seq_vld,busy,done})", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; use_def = 1'b0; pattern = '0; rep = '0; gap = '0; abort = 1'b0; loop = 1'b0;
    endtask

    initial begin
        logic [11:0] bits12;
        logic [3:0]  def_pat;

        // ---------------- vector table ----------------
        // 1: default pattern once
        v(1,1,4'h0,0,0,0, 1,1,1,0);
        v(0,1,4'h0,0,0,0, 0,1,1,0);
        v(0,1,4'h0,0,0,0, 0,1,1,0);
        v(0,1,4'h0,0,0,0, 1,1,1,0);
        v(0,1,4'h0,0,0,0, 0,0,0,1);
        v(0,1,4'h0,0,0,0, 0,0,0,0);
        // 2: user pattern 1101, rep=2, gap=0 -> 12 contiguous bits
        bits12 = 12'b1101_1101_1101;
        for (int k = 0; k < 12; k++)
            v(k == 0, 0, 4'b1101, 2, 0, 0, bits12[11-k], 1, 1, 0);
        v(0,0,4'b1101,2,0,0, 0,0,0,1);
        v(0,0,4'b1101,2,0,0, 0,0,0,0);
        // 3: default pattern, rep=1, gap=2; inputs changed after start
        v(1,1,4'h0,1,2,0, 1,1,1,0);
        v(0,0,4'hF,7,0,0, 0,1,1,0);
        v(0,0,4'hF,7,0,0, 0,1,1,0);
        v(0,0,4'hF,7,0,0, 1,1,1,0);
        v(0,0,4'hF,7,0,0, 0,0,1,0);
        v(0,0,4'hF,7,0,0, 0,0,1,0);
        v(0,0,4'hF,7,0,0, 1,1,1,0);
        v(0,0,4'hF,7,0,0, 0,1,1,0);
        v(0,0,4'hF,7,0,0, 0,1,1,0);
        v(0,0,4'hF,7,0,0, 1,1,1,0);
        v(0,0,4'hF,7,0,0, 0,0,0,1);
        v(0,0,4'hF,7,0,0, 0,0,0,0);
        // 4: start held while busy is ignored; start in done cycle accepted
        v(1,1,4'h0,0,0,0, 1,1,1,0);
        v(1,0,4'b0110,0,0,0, 0,1,1,0);
        v(1,0,4'b0110,0,0,0, 0,1,1,0);
        v(1,0,4'b0110,0,0,0, 1,1,1,0);
        v(1,0,4'b0110,0,0,0, 0,0,0,1);
        v(1,0,4'b0110,0,0,0, 0,1,1,0);
        v(0,0,4'b0110,0,0,0, 1,1,1,0);
        v(0,0,4'b0110,0,0,0, 1,1,1,0);
        v(0,0,4'b0110,0,0,0, 0,1,1,0);
        v(0,0,4'b0110,0,0,0, 0,0,0,1);
        v(0,0,4'b0110,0,0,0, 0,0,0,0);
        // abort together with start in IDLE: start dropped
        v(1,1,4'h0,0,0,1, 0,0,0,0);
        v(0,1,4'h0,0,0,0, 0,0,0,0);
        // 5: abort on the 2nd bit of a rep=3 burst
        v(1,1,4'h0,3,0,0, 1,1,1,0);
        v(0,1,4'h0,3,0,0, 0,1,1,0);
        v(0,1,4'h0,3,0,1, 0,0,0,0);
        v(0,1,4'h0,3,0,0, 0,0,0,0);
        v(0,1,4'h0,3,0,0, 0,0,0,0);
        v(0,1,4'h0,3,0,0, 0,0,0,0);
        // abort during a gap
        v(1,1,4'h0,1,2,0, 1,1,1,0);
        v(0,1,4'h0,1,2,0, 0,1,1,0);
        v(0,1,4'h0,1,2,0, 0,1,1,0);
        v(0,1,4'h0,1,2,0, 1,1,1,0);
        v(0,1,4'h0,1,2,0, 0,0,1,0);
        v(0,1,4'h0,1,2,1, 0,0,0,0);
        v(0,1,4'h0,1,2,0, 0,0,0,0);
        v(0,1,4'h0,1,2,0, 0,0,0,0);

        // ---------------- reset state ----------------
        idle_inputs();
        #1 check("reset_async", {seq, seq_vld, busy, done}, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("reset_idle", {seq, seq_vld, busy, done}, 4'b0000);

        // ---------------- apply table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; use_def = vecs[i].ud; pattern = vecs[i].pat;
            rep = vecs[i].rp; gap = vecs[i].gp; abort = vecs[i].ab;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), {seq, seq_vld, busy, done}, vecs[i].exp);
        end
        idle_inputs();

        // ---------------- reset mid-gap ----------------
        start = 1'b1; use_def = 1'b1; rep = 4'd1; gap = 3'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("rst_pre_gap", {seq, seq_vld, busy, done}, 4'b0010);
        #2 rst = 1'b1;
        #1 check("rst_async_gap", {seq, seq_vld, busy, done}, 4'b0000);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 check($sformatf("rst_after%0d", k), {seq, seq_vld, busy, done}, 4'b0000);
        end
        idle_inputs();

`ifdef SEQ_GEN_LOOP_EN
        // ---------------- endless loop with gap=1 ----------------
        def_pat = 4'b1001;
        start = 1'b1; use_def = 1'b1; rep = 4'd0; gap = 3'd1; loop = 1'b1;
        for (int c = 0; c < 22 * 5; c++) begin
            @(posedge clk);
            #1 start = 1'b0;
            if ((c % 5) < 4)
                check($sformatf("loop%0d", c), {seq, seq_vld, busy, done},
                      {def_pat[3 - (c % 5)], 1'b1, 1'b1, 1'b0});
            else
                check($sformatf("loop%0d", c), {seq, seq_vld, busy, done}, 4'b0010);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("loop_abort", {seq, seq_vld, busy, done}, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 check($sformatf("loop_post%0d", k), {seq, seq_vld, busy, done}, 4'b0000);
        end
        idle_inputs();
`else
        def_pat = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Serial pattern generator. It is the transmit-side counterpart of the serial sequence detector. It emits a programmable PAT_W-bit pattern MSB-first on a 1-bit serial output, repeated a programmable number of times with an optional idle gap between repetitions. A start/busy/done handshake connects it to a controller, and seq_vld qualifies each bit for a downstream detector or checker.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
PAT_DEF, 4'b1001, pattern used when use_def=1
CNT_W, 4, width of repeat count
GAP_W, 3, width of inter-repetition gap count

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request to begin a burst; sampled only in IDLE
use_def  input  1  1: send PAT_DEF; 0: send pattern
pattern  input  PAT_W  user pattern, sampled on the accepted start
rep  input  CNT_W  number of extra repetitions (0 = pattern sent once), sampled on the accepted start
gap  input  GAP_W  idle cycles between repetitions, sampled on the accepted start
abort  input  1  synchronous cancel
seq  output  1  serial data bit, registered
seq_vld  output  1  seq is a valid pattern bit, registered
busy  output  1  burst in progress, registered
done  output  1  one-cycle pulse when a burst completes normally, registered

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; seq=0, seq_vld=0, busy=0, done=0; shift, bit, repeat and gap counters all 0. Reset asserted mid-burst kills the burst immediately and produces no done pulse.
- States:
  - IDLE: wait for start.
  - SHIFT: drive the pattern bits.
  - GAP: idle cycles between repetitions.
- IDLE + start=1 at edge T:
  - Latch the pattern (PAT_DEF or pattern), rep and gap.
  - Load the shift register.
  - Go to SHIFT.
  - From cycle T+1: seq = pattern MSB, seq_vld=1, busy=1.
- SHIFT:
  - One bit per cycle, MSB first, for exactly PAT_W cycles. seq_vld=1 throughout.
  - After the last bit with repetitions remaining and gap>0: go to GAP.
  - After the last bit with repetitions remaining and gap=0: reload the latched pattern and continue in SHIFT with no bubble.
  - After the last bit with no repetitions remaining: go to IDLE. In the first IDLE cycle, done=1, busy=0, seq_vld=0, seq=0.
- GAP:
  - Lasts exactly the latched gap cycles, with seq=0, seq_vld=0, busy=1.
  - Then reload the pattern, decrement the repeat counter and return to SHIFT.
- Burst length is (rep+1)*PAT_W + rep*gap cycles from the first bit to the last bit or gap cycle.
- start while busy=1 is ignored; it is neither queued nor used to change the latched values.
- start in the done cycle is accepted; the next burst's first bit follows on the next cycle.
- Input changes to pattern, rep, gap and use_def after acceptance have no effect on the running burst.
- abort=1 in SHIFT or GAP: next cycle state=IDLE, seq=0, seq_vld=0, busy=0, and no done pulse.
- abort in IDLE has no effect.
- abort and start asserted together in IDLE: abort wins and the start is dropped.
- seq is 0 whenever seq_vld=0.

Optional Feature:
Macro SEQ_GEN_LOOP_EN.
- Defined:
  - Extra input port loop (1 bit), sampled on the accepted start.
  - If loop=1, the burst repeats indefinitely: rep is ignored, the gap still applies, and done never pulses.
  - The burst ends only on abort or rst.
- Undefined: the port is absent and behaviour is exactly as above.

Test Plan:
1. use_def=1, rep=0, gap=0, start pulse at T -> seq_vld=1 on T+1..T+4 with seq=1,0,0,1; done=1 on T+5; busy=1 on T+1..T+4.
2. use_def=0, pattern=4'b1101, rep=2, gap=0 -> 12 contiguous valid bits 110111011101; a single done pulse the cycle after the last bit.
3. use_def=1, rep=1, gap=2 -> bits 1001, then 2 cycles with seq_vld=0 and seq=0, then 1001, then done; pattern/rep/gap changed mid-burst -> output unchanged.
4. start re-pulsed while busy -> ignored; start asserted in the done cycle -> second burst begins next cycle with no gap.
5. abort on the 2nd bit of a rep=3 burst -> IDLE next cycle, outputs 0, no done; rst pulse mid-gap -> immediate IDLE, all outputs 0.
6. With SEQ_GEN_LOOP_EN defined, loop=1, gap=1 -> 1001 plus 1 idle cycle repeated for more than 20 periods with no done; abort ends the burst cleanly.
